// File: rtl/mux_8x1_rr_if.sv
// Lane-side and output-side signals of the 8:1 round-robin multiplexer.
// out_par exists only when MUX_PARITY_EN is defined.
interface mux_8x1_rr_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned N_LANES = 8;
    localparam int unsigned SEL_W   = 3;

    logic [N_LANES-1:0]        in_valid;
    logic [N_LANES*DATA_W-1:0] in_data;
    logic [N_LANES-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;
`ifdef MUX_PARITY_EN
    logic                      out_par;
`endif

    // Source/sink side (lanes plus the far-end demultiplexer).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
`ifdef MUX_PARITY_EN
        , input out_par
`endif
    );

    // Multiplexer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
`ifdef MUX_PARITY_EN
        , output out_par
`endif
    );

endinterface : mux_8x1_rr_if

// File: rtl/mux_8x1_rr.sv
// Eight-lane round-robin multiplexer with a one-beat registered output and full backpressure.
// Optional even-parity output flop is compiled in with MUX_PARITY_EN.
module mux_8x1_rr #(
    parameter int unsigned DATA_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mux_8x1_rr_if.slave   io_bus
);

    localparam int unsigned N_LANES = 8;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_ptr;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
`ifdef MUX_PARITY_EN
    logic                r_out_par;
`endif

    logic                w_load_en;
    logic                w_found;
    logic [SEL_W-1:0]    w_gnt;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_gnt_data;

    // First valid lane at or after the pointer, wrapping modulo 8.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (!w_found && io_bus.in_valid[SEL_W'(r_ptr + SEL_W'(i))]) begin
                w_found = 1'b1;
                w_gnt   = SEL_W'(r_ptr + SEL_W'(i));
            end
        end
    end

    assign w_load_en       = (r_state == ST_EMPTY) || io_bus.out_ready;
    assign w_xfer          = w_found && w_load_en && i_rst_n;
    assign io_bus.in_ready = w_xfer ? (N_LANES'(1) << w_gnt) : '0;

    // Word of the granted lane; only reaches the output through the flops.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data = io_bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load wins over a drain, so back-to-back beats never leave a bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_xfer && io_bus.out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output payload and pointer move only on a grant; otherwise they hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_data <= '0;
            r_out_sel  <= '0;
            r_ptr      <= '0;
        end else if (w_xfer) begin
            r_out_data <= w_gnt_data;
            r_out_sel  <= w_gnt;
            r_ptr      <= w_gnt + SEL_W'(1);
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_par <= 1'b0;
        end else if (w_xfer) begin
            r_out_par <= ^w_gnt_data;
        end
    end

    assign io_bus.out_par = r_out_par;
`endif

    assign io_bus.out_valid = r_state;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_sel   = r_out_sel;

endmodule : mux_8x1_rr

// File: tb/tb_mux_8x1_rr.sv
// Self-checking bench for mux_8x1_rr: directed scenarios plus a randomized run
// against a queue-free behavioural model of the round-robin arbiter.
module tb_mux_8x1_rr;

    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_8x1_rr_if #(.DATA_W(DATA_W)) u_bus ();

    mux_8x1_rr #(.DATA_W(DATA_W)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (u_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    bit          m_par;
    logic [7:0]  exp_ready;
    logic [7:0]  lane_data [8];

    function automatic logic [7:0] model_grant();
        if (!rst_n) return 8'h00;
        if (m_valid && !u_bus.out_ready) return 8'h00;
        for (int j = 0; j < 8; j++) begin
            int k;
            k = (m_ptr + j) % 8;
            if (u_bus.in_valid[k]) return 8'(1) << k;
        end
        return 8'h00;
    endfunction

    // Called at a falling edge: drive inputs, then let combinational logic settle.
    task automatic apply(input logic [7:0] v, input logic ordy, input logic rst);
        rst_n           = rst;
        u_bus.in_valid  = v;
        u_bus.out_ready = ordy;
        for (int k = 0; k < 8; k++) u_bus.in_data[k*DATA_W +: DATA_W] = lane_data[k];
        #1;
        exp_ready = model_grant();
    endtask

    // Advance one clock and update the model; returns at the next falling edge.
    task automatic tick();
        logic [7:0] g;
        g = model_grant();
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_data = 8'h00; m_sel = 0; m_ptr = 0; m_par = 0;
        end else if (g != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (g[k]) begin
                    m_valid = 1; m_data = lane_data[k]; m_sel = k;
                    m_par = ^lane_data[k]; m_ptr = (k + 1) % 8;
                end
            end
        end else if (m_valid && u_bus.out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) lane_data[k] = 8'h00;
        apply(8'hFF, 1'b1, 1'b0);
        n_tests++;
        if (u_bus.in_ready !== 8'h00) begin
            n_fail++; $display("FAIL reset_ready got=%h exp=00", u_bus.in_ready);
        end
        tick();
        apply(8'h00, 1'b1, 1'b0);
        tick();
        n_tests++;
        if (u_bus.out_valid !== 1'b0 || u_bus.out_sel !== 3'd0 || u_bus.out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out got v=%b s=%0d d=%h exp v=0 s=0 d=00",
                     u_bus.out_valid, u_bus.out_sel, u_bus.out_data);
        end
`ifdef MUX_PARITY_EN
        n_tests++;
        if (u_bus.out_par !== 1'b0) begin
            n_fail++; $display("FAIL reset_par got=%b exp=0", u_bus.out_par);
        end
`endif
        for (int i = 0; i < 10; i++) begin
            apply(8'h00, 1'b1, 1'b1);
            n_tests++;
            if (u_bus.in_ready !== 8'h00) begin
                n_fail++; $display("FAIL idle_ready cyc=%0d got=%h exp=00", i, u_bus.in_ready);
            end
            tick();
            n_tests++;
            if (u_bus.out_valid !== 1'b0 || u_bus.out_sel !== 3'd0) begin
                n_fail++;
                $display("FAIL idle_out cyc=%0d got v=%b s=%0d exp v=0 s=0",
                         i, u_bus.out_valid, u_bus.out_sel);
            end
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) lane_data[k] = 8'(8'h10 + k);
        for (int i = 0; i < 9; i++) begin
            apply(8'hFF, 1'b1, 1'b1);
            n_tests++;
            if (u_bus.in_ready !== (8'(1) << (i % 8)) || $countones(u_bus.in_ready) != 1) begin
                n_fail++;
                $display("FAIL wrap_ready cyc=%0d got=%h exp=%h", i, u_bus.in_ready, 8'(1) << (i % 8));
            end
            tick();
            n_tests++;
            if (u_bus.out_valid !== 1'b1 || u_bus.out_sel !== 3'(i % 8) ||
                u_bus.out_data !== 8'(8'h10 + (i % 8))) begin
                n_fail++;
                $display("FAIL wrap_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, u_bus.out_valid, u_bus.out_sel, u_bus.out_data, i % 8, 8'(8'h10 + (i % 8)));
            end
        end
        apply(8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_ptr_order();
        for (int k = 0; k < 8; k++) lane_data[k] = 8'($urandom);
        apply(8'h00, 1'b1, 1'b0);
        tick();
        apply(8'h04, 1'b1, 1'b1);
        tick();
        apply(8'h42, 1'b1, 1'b1);
        n_tests++;
        if (u_bus.in_ready !== 8'h40) begin
            n_fail++; $display("FAIL ptr3_first_ready got=%h exp=40", u_bus.in_ready);
        end
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'd6 || u_bus.out_data !== lane_data[6] || u_bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ptr3_first_out got s=%0d d=%h exp s=6 d=%h", u_bus.out_sel, u_bus.out_data, lane_data[6]);
        end
        apply(8'h02, 1'b1, 1'b1);
        n_tests++;
        if (u_bus.in_ready !== 8'h02) begin
            n_fail++; $display("FAIL ptr3_second_ready got=%h exp=02", u_bus.in_ready);
        end
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'd1 || u_bus.out_data !== lane_data[1]) begin
            n_fail++;
            $display("FAIL ptr3_second_out got s=%0d d=%h exp s=1 d=%h", u_bus.out_sel, u_bus.out_data, lane_data[1]);
        end
        apply(8'h00, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (u_bus.out_valid !== 1'b0 || u_bus.out_sel !== 3'd1 || u_bus.out_data !== lane_data[1]) begin
            n_fail++;
            $display("FAIL drain_hold got v=%b s=%0d d=%h exp v=0 s=1 d=%h",
                     u_bus.out_valid, u_bus.out_sel, u_bus.out_data, lane_data[1]);
        end
    endtask

    task automatic test_stall();
        int         held_sel;
        logic [7:0] held_data;
        for (int k = 0; k < 8; k++) lane_data[k] = 8'($urandom);
        apply(8'hFF, 1'b1, 1'b1);
        tick();
        held_sel  = m_sel;
        held_data = m_data;
        for (int i = 0; i < 5; i++) begin
            apply(8'hFF, 1'b0, 1'b1);
            n_tests++;
            if (u_bus.in_ready !== 8'h00) begin
                n_fail++; $display("FAIL stall_ready cyc=%0d got=%h exp=00", i, u_bus.in_ready);
            end
            tick();
            n_tests++;
            if (u_bus.out_valid !== 1'b1 || u_bus.out_sel !== 3'(held_sel) || u_bus.out_data !== held_data) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, u_bus.out_valid, u_bus.out_sel, u_bus.out_data, held_sel, held_data);
            end
        end
        apply(8'hFF, 1'b1, 1'b1);
        n_tests++;
        if (u_bus.in_ready !== (8'(1) << ((held_sel + 1) % 8))) begin
            n_fail++;
            $display("FAIL stall_release_ready got=%h exp=%h", u_bus.in_ready, 8'(1) << ((held_sel + 1) % 8));
        end
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'((held_sel + 1) % 8) || u_bus.out_data !== lane_data[(held_sel + 1) % 8]) begin
            n_fail++;
            $display("FAIL stall_release_out got s=%0d d=%h exp s=%0d", u_bus.out_sel, u_bus.out_data, (held_sel + 1) % 8);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            lane_data[4] = 8'($urandom);
            apply(8'h10, 1'b1, 1'b1);
            n_tests++;
            if (u_bus.in_ready !== 8'h10) begin
                n_fail++; $display("FAIL b2b_ready cyc=%0d got=%h exp=10", i, u_bus.in_ready);
            end
            tick();
            n_tests++;
            if (u_bus.out_valid !== 1'b1 || u_bus.out_sel !== 3'd4 || u_bus.out_data !== lane_data[4]) begin
                n_fail++;
                $display("FAIL b2b_out cyc=%0d got v=%b s=%0d d=%h exp v=1 s=4 d=%h",
                         i, u_bus.out_valid, u_bus.out_sel, u_bus.out_data, lane_data[4]);
            end
        end
        apply(8'h10, 1'b1, 1'b0);
        n_tests++;
        if (u_bus.in_ready !== 8'h00) begin
            n_fail++; $display("FAIL midrst_ready got=%h exp=00", u_bus.in_ready);
        end
        tick();
        n_tests++;
        if (u_bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valid got=%b exp=0", u_bus.out_valid);
        end
        apply(8'hFF, 1'b1, 1'b1);
        n_tests++;
        if (u_bus.in_ready !== 8'h01) begin
            n_fail++; $display("FAIL postrst_ready got=%h exp=01", u_bus.in_ready);
        end
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'd0 || u_bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL postrst_out got v=%b s=%0d exp v=1 s=0", u_bus.out_valid, u_bus.out_sel);
        end
    endtask

    task automatic test_parity();
        apply(8'h00, 1'b1, 1'b0);
        tick();
        lane_data[2] = 8'hA7;
        lane_data[5] = 8'h03;
        apply(8'h24, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'd2 || u_bus.out_data !== 8'hA7) begin
            n_fail++; $display("FAIL par_beat0 got s=%0d d=%h exp s=2 d=a7", u_bus.out_sel, u_bus.out_data);
        end
`ifdef MUX_PARITY_EN
        n_tests++;
        if (u_bus.out_par !== 1'b1) begin
            n_fail++; $display("FAIL par_bit0 got=%b exp=1", u_bus.out_par);
        end
`endif
        apply(8'h20, 1'b1, 1'b1);
        tick();
        n_tests++;
        if (u_bus.out_sel !== 3'd5 || u_bus.out_data !== 8'h03) begin
            n_fail++; $display("FAIL par_beat1 got s=%0d d=%h exp s=5 d=03", u_bus.out_sel, u_bus.out_data);
        end
`ifdef MUX_PARITY_EN
        n_tests++;
        if (u_bus.out_par !== 1'b0) begin
            n_fail++; $display("FAIL par_bit1 got=%b exp=0", u_bus.out_par);
        end
`endif
        apply(8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [7:0] pend;
        int         waits [8];
        bit         rst;
        logic       ordy;
        pend = 8'h00;
        for (int k = 0; k < 8; k++) waits[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 8; k++) begin
                if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
                    pend[k]      = 1'b1;
                    lane_data[k] = 8'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 199) != 0);
            apply(pend, ordy, rst);
            n_tests++;
            if (u_bus.in_ready !== exp_ready || $countones(u_bus.in_ready) > 1) begin
                n_fail++; $display("FAIL rnd_ready cyc=%0d got=%h exp=%h", c, u_bus.in_ready, exp_ready);
            end
            // Fairness: a lane kept valid sees at most 7 foreign grants before its own.
            for (int k = 0; k < 8; k++) begin
                if (!rst) waits[k] = 0;
                else if (exp_ready[k]) begin
                    n_tests++;
                    if (waits[k] > 7) begin
                        n_fail++; $display("FAIL rnd_fair cyc=%0d lane=%0d waited=%0d max=7", c, k, waits[k]);
                    end
                    waits[k] = 0;
                end else if (pend[k] && exp_ready != 8'h00) waits[k]++;
            end
            tick();
            pend = pend & ~exp_ready;
            n_tests++;
            if (u_bus.out_valid !== m_valid || u_bus.out_sel !== 3'(m_sel) || u_bus.out_data !== m_data) begin
                n_fail++;
                $display("FAIL rnd_out cyc=%0d got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                         c, u_bus.out_valid, u_bus.out_sel, u_bus.out_data, m_valid, m_sel, m_data);
            end
`ifdef MUX_PARITY_EN
            n_tests++;
            if (u_bus.out_par !== m_par) begin
                n_fail++; $display("FAIL rnd_par cyc=%0d got=%b exp=%b", c, u_bus.out_par, m_par);
            end
`endif
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        u_bus.in_valid  = 8'h00;
        u_bus.in_data   = '0;
        u_bus.out_ready = 1'b1;
        m_ptr = 0; m_valid = 0; m_data = 8'h00; m_sel = 0; m_par = 0;
        exp_ready = 8'h00;
        @(negedge clk);
        test_reset();
        test_wrap();
        test_ptr_order();
        test_stall();
        test_back_to_back();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mux_8x1_rr
